pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the ALU operand-forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one ALU source; the youngest producer
// (EX/MEM) wins over MEM/WB, and x0 is never forwarded.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_reg_write,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_reg_write,
    output logic [1:0] sel
);

    // NOTE: the default assignment first keeps this purely combinational;
    // a path that leaves sel unassigned would infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait/timeout FSM, load-use stall,
// branch flush, operand forwarding and stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       idex_rs1,
    input  logic [4:0]       idex_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_reg_write,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_freeze;
    logic              load_use;
    logic              load_use_stall;
    logic              branch_flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_W'(WAIT_TIMEOUT)) begin
                        state <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ERR;
            endcase
        end
    end

    // ERR keeps the whole pipeline frozen until reset.
    assign mem_freeze  = (state == ERR) || (dmem_req && !dmem_ready);
    assign mem_timeout = (state == ERR);

    assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == idex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == idex_rd)));

    // Priority: memory freeze > branch flush > load-use. A branch seen during
    // a freeze stays in EX and is flushed once the freeze drops.
    assign branch_flush   = ex_branch_taken && !mem_freeze;
    assign load_use_stall = load_use && !ex_branch_taken && !mem_freeze;

    assign pc_stall    = mem_freeze || load_use_stall;
    assign ifid_stall  = mem_freeze || load_use_stall;
    assign idex_stall  = mem_freeze;
    assign exmem_stall = mem_freeze;
    assign memwb_flush = mem_freeze;
    assign ifid_flush  = branch_flush;
    assign idex_flush  = branch_flush || load_use_stall;

    fwd_sel u_fwd_a (
        .rs              (idex_rs1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs              (idex_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .sel             (fwd_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branch_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, forwarding, memory wait,
// counter saturation and the timeout/reset path.
module tb_pipeline_hazard_ctrl;

    localparam int WAIT_TIMEOUT = 4;
    localparam int CNT_W        = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic             id_uses_rs1, id_uses_rs2, idex_mem_read;
    logic             exmem_reg_write, memwb_reg_write;
    logic             ex_branch_taken, dmem_req, dmem_ready;
    logic             pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic             ifid_flush, idex_flush, memwb_flush;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .idex_rs1        (idex_rs1),
        .idex_rs2        (idex_rs2),
        .idex_rd         (idex_rd),
        .idex_mem_read   (idex_mem_read),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .exmem_stall     (exmem_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_flush     (memwb_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Stall/flush vector order: pc, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_f
    function automatic logic [31:0] ctl();
        return {25'd0, pc_stall, ifid_stall, idex_stall, exmem_stall,
                ifid_flush, idex_flush, memwb_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_mem_read = 0;
        exmem_rd = 0; exmem_reg_write = 0; memwb_rd = 0; memwb_reg_write = 0;
        ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("reset_ctl", ctl(), 32'h00);
        check("reset_stall_cnt", 32'(stall_cycles), 0);
        check("reset_flush_cnt", 32'(flush_count), 0);
        check("reset_timeout", 32'(mem_timeout), 0);
        #9 rst_n = 1'b1;
        tick();

        // Load-use on rs1
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        #1 check("loaduse_rs1_ctl", ctl(), 32'b1100010);
        tick();
        clear_inputs();
        #1 check("loaduse_released", ctl(), 32'h00);
        check("loaduse_stall_cnt", 32'(stall_cycles), 1);

        // Destination x0 never causes a load-use stall
        idex_mem_read = 1; idex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
        #1 check("loaduse_x0_ctl", ctl(), 32'h00);
        tick();
        check("loaduse_x0_cnt", 32'(stall_cycles), 1);

        // Load-use on rs2, then same regs without the use flag
        clear_inputs();
        idex_mem_read = 1; idex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
        #1 check("loaduse_rs2_ctl", ctl(), 32'b1100010);
        id_uses_rs2 = 0;
        #1 check("loaduse_rs2_unused", ctl(), 32'h00);
        id_uses_rs2 = 1;
        tick();
        check("loaduse_rs2_cnt", 32'(stall_cycles), 2);

        // Branch overrides a simultaneous load-use
        clear_inputs();
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; ex_branch_taken = 1;
        #1 check("branch_ctl", ctl(), 32'b0000110);
        tick();
        clear_inputs();
        #1 check("branch_flush_cnt", 32'(flush_count), 1);
        check("branch_stall_cnt", 32'(stall_cycles), 2);

        // Memory wait of 3 cycles with a branch held in EX
        dmem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("memwait_ctl_%0d", i), ctl(), 32'b1111001);
            tick();
        end
        dmem_ready = 1;
        #1 check("memwait_release_ctl", ctl(), 32'b0000110);
        check("memwait_stall_cnt", 32'(stall_cycles), 5);
        check("memwait_flush_cnt_held", 32'(flush_count), 1);
        tick();
        clear_inputs();
        #1 check("memwait_flush_cnt", 32'(flush_count), 2);
        check("memwait_timeout", 32'(mem_timeout), 0);
        tick();
        check("memwait_back_to_run", ctl(), 32'h00);

        // Forwarding priority
        exmem_rd = 7; memwb_rd = 7; idex_rs1 = 7; idex_rs2 = 7;
        exmem_reg_write = 1; memwb_reg_write = 1;
        #1 check("fwd_a_mem", 32'(fwd_a), 2);
        check("fwd_b_mem", 32'(fwd_b), 2);
        exmem_reg_write = 0;
        #1 check("fwd_a_wb", 32'(fwd_a), 1);
        idex_rs1 = 0;
        #1 check("fwd_a_rf", 32'(fwd_a), 0);
        check("fwd_b_wb", 32'(fwd_b), 1);
        exmem_reg_write = 1; exmem_rd = 3;
        #1 check("fwd_b_wb_mismatch", 32'(fwd_b), 1);
        memwb_rd = 0; idex_rs2 = 0;
        #1 check("fwd_b_x0", 32'(fwd_b), 0);
        clear_inputs();
        tick();

        // Saturation of stall_cycles: 5 + 12 exceeds 15
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
        for (int i = 0; i < 12; i++) tick();
        check("stall_cnt_saturate", 32'(stall_cycles), 15);
        clear_inputs();

        // Timeout: ERR four cycles after MEM_WAIT entry
        dmem_req = 1; dmem_ready = 0;
        tick();
        for (int i = 1; i < WAIT_TIMEOUT; i++) begin
            tick();
            check($sformatf("timeout_pending_%0d", i), 32'(mem_timeout), 0);
        end
        tick();
        check("timeout_set", 32'(mem_timeout), 1);
        dmem_req = 0; ex_branch_taken = 1;
        #1 check("err_freeze_ctl", ctl(), 32'b1111001);
        tick();
        tick();
        check("timeout_sticky", 32'(mem_timeout), 1);
        check("err_no_flush_cnt", 32'(flush_count), 2);

        // Asynchronous reset clears the error between clock edges
        rst_n = 1'b0;
        #1 check("async_rst_timeout", 32'(mem_timeout), 0);
        check("async_rst_stall_cnt", 32'(stall_cycles), 0);
        check("async_rst_flush_cnt", 32'(flush_count), 0);
        check("async_rst_branch_ctl", ctl(), 32'b0000110);
        #2 rst_n = 1'b1;
        clear_inputs();
        tick();
        check("post_rst_timeout", 32'(mem_timeout), 0);
        check("post_rst_ctl", ctl(), 32'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
